sifs_resp_sched: RTL
====================

// Module: sifs_resp_sched
// PURPOSE
//  Control-response scheduler: after a correctly received frame addressed to us, it schedules an ACK (data/mgmt) or a CTS (RTS) one SIFS later.
//  Consumes rx-side header/FCS info; presents a held request (RA/duration/rate) to the tx path, which accepts it with resp_ack. Bypasses CSMA backoff by design.
// PARAMETERS
//  PREAMBLE_SIG_US  20  legacy preamble+SIGNAL time, us
//  OFDM_SYM_US      4   OFDM symbol time, us
//  LEAD_US          0   PHY tx latency compensation subtracted from SIFS wait, us
//  REQ_TIMEOUT_US   16  max time resp_req waits for resp_ack before the request is dropped, us
// PORTS
//  clk                      in   1   clock
//  rstn                     in   1   reset, synchronous, active-low
//  tsf_pulse_1M             in   1   1-cycle pulse every 1 us
//  pkt_header_valid_strobe  in   1   start of a new rx packet
//  signal_rate              in   8   rx rate: [7]=HT, [3:0]=legacy rate code / MCS
//  FC_type                  in   2   rx frame type
//  FC_subtype               in   4   rx frame subtype
//  duration                 in   16  rx Duration/ID field
//  addr1                    in   48  rx RA
//  addr2                    in   48  rx TA
//  self_mac_addr            in   48  own MAC address
//  fcs_in_strobe            in   1   FCS check result valid (1 cycle)
//  fcs_valid                in   1   FCS ok, qualified by fcs_in_strobe
//  sifs_time                in   7   SIFS, us
//  resp_enable              in   2   [0]=ACK enable, [1]=CTS enable
//  nav_zero                 in   1   own NAV is 0 (CTS precondition)
//  resp_ack                 in   1   tx path accepted request (1 cycle)
//  resp_req                 out  1   response request, held until resp_ack/timeout/abort
//  resp_is_cts              out  1   0=ACK, 1=CTS
//  resp_ra                  out  48  RA of response (= rx addr2)
//  resp_duration            out  16  Duration field of response
//  resp_rate                out  4   legacy rate code of response
//  resp_drop                out  1   1-cycle pulse: scheduled response abandoned
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, timer 0. rstn low mid-operation -> outputs 0 at next edge.
//  - FSM IDLE -> SIFS_WAIT -> REQ -> IDLE.
//  - Rx fields (FC_*, duration, addr*, signal_rate) are sampled in the fcs_in_strobe cycle and are stable then.
//  - IDLE, on fcs_in_strobe:
//    - ack_q = fcs_valid & resp_enable[0] & addr1==self & FC_type in {00,10}.
//    - cts_q = fcs_valid & resp_enable[1] & addr1==self & FC_type==01 & FC_subtype==1011 & nav_zero.
//    - Either set -> latch resp_ra/is_cts/rate/duration; timer = max(sifs_time-LEAD_US, 0); go to SIFS_WAIT.
//  - SIFS_WAIT: timer==0 -> next cycle resp_req=1, timer = REQ_TIMEOUT_US, go to REQ; else decrement on tsf_pulse_1M.
//  - REQ: resp_ack -> resp_req=0 next cycle, go to IDLE. Timer expires -> resp_req=0, resp_drop pulse, go to IDLE.
//    resp_ack in the expiry cycle -> ack wins, no drop.
//  - Priority: rstn > pkt_header_valid_strobe > fcs_in_strobe.
//    Header strobe in SIFS_WAIT or REQ -> IDLE, resp_req=0, resp_drop pulse. Header strobe in IDLE -> no effect.
//  - fcs_in_strobe outside IDLE ignored; resp_ack outside REQ ignored. Latched outputs stable while resp_req=1.
//  - Rate map:
//    - legacy 1011/1111 -> 1011 (6M); 1010/1110 -> 1010 (12M); other legacy -> 1001 (24M).
//    - HT MCS0 -> 1011; MCS1-2 -> 1010; MCS>=3 -> 1001.
//  - resp_time = PREAMBLE_SIG_US + OFDM_SYM_US*n_sym(14-byte frame at resp_rate), giving 44/32/28 us for 6M/12M/24M.
//  - resp_duration: duration[15]=1 -> 0; else {1'b0, max(duration[14:0]-sifs_time-resp_time, 0)}. 16-bit unsigned, no wrap. Same formula for ACK and CTS.
// STRUCTURE
//  - Shared package: FC type/subtype constants, legacy rate codes, FSM state encoding.
//  - Sub-module: n_sym_len14_pkt (ht_flag=0, rate_mcs=resp_rate) for n_sym; everything else inline.
// TESTING
//  - Data frame: addr1=self, addr2=A, duration=44, rate 1001, sifs=16 -> resp_req rises 1 clk after 16th tsf pulse; ra=A, is_cts=0, rate=1001, duration=0.
//  - RTS: addr1=self, duration=500, rate 1011, nav_zero=1 -> is_cts=1, rate=1011, duration=500-16-44=440; resp_ack -> resp_req low next cycle.
//  - RTS with nav_zero=0; data with addr1!=self; fcs_valid=0; resp_enable=0 -> resp_req never asserts.
//  - pkt_header_valid_strobe 5 us into SIFS_WAIT -> no resp_req, one resp_drop pulse; next valid frame responded to normally.
//  - No resp_ack -> resp_req held 16 us then low with drop pulse. resp_ack in the expiry cycle -> no drop.
//  - duration=0x8000 or duration=10 -> resp_duration=0. rstn low during REQ -> all outputs 0 next edge.

Source files
------------

// File: rtl/sifs_resp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sifs_resp_sched_pkg
// Description : Shared definitions for the SIFS control-response scheduler.
//               Holds the 802.11 frame-control type/subtype constants, the
//               legacy OFDM rate codes, the FSM state encoding and the
//               rx-rate to response-rate mapping function.
// Revision    : 1.0 - initial release
// ============================================================================
package sifs_resp_sched_pkg;

    // Frame control type / subtype
    localparam logic [1:0] c_FC_TYPE_MGMT   = 2'b00;
    localparam logic [1:0] c_FC_TYPE_CTRL   = 2'b01;
    localparam logic [1:0] c_FC_TYPE_DATA   = 2'b10;
    localparam logic [3:0] c_FC_SUBTYPE_RTS = 4'b1011;

    // Legacy OFDM rate codes (SIGNAL field RATE bits)
    localparam logic [3:0] c_RATE_6M  = 4'b1011;
    localparam logic [3:0] c_RATE_9M  = 4'b1111;
    localparam logic [3:0] c_RATE_12M = 4'b1010;
    localparam logic [3:0] c_RATE_18M = 4'b1110;
    localparam logic [3:0] c_RATE_24M = 4'b1001;
    localparam logic [3:0] c_RATE_36M = 4'b1101;
    localparam logic [3:0] c_RATE_48M = 4'b1000;
    localparam logic [3:0] c_RATE_54M = 4'b1100;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SIFS_WAIT = 2'd1,
        ST_REQ       = 2'd2
    } state_t;

    // Control responses go out at the highest mandatory rate that does not
    // exceed the rate of the frame being answered.
    function automatic logic [3:0] resp_rate_map(input logic ht, input logic [3:0] code);
        logic [3:0] rate;
        rate = c_RATE_24M;
        if (ht) begin
            case (code)
                4'd0:       rate = c_RATE_6M;
                4'd1, 4'd2: rate = c_RATE_12M;
                default:    rate = c_RATE_24M;
            endcase
        end else begin
            case (code)
                c_RATE_6M,  c_RATE_9M:  rate = c_RATE_6M;
                c_RATE_12M, c_RATE_18M: rate = c_RATE_12M;
                default:                rate = c_RATE_24M;
            endcase
        end
        return rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sifs_resp_sched_n_sym.sv
`default_nettype none
// ============================================================================
// Module      : n_sym_len14_pkt
// Description : Number of OFDM data symbols for a 14-byte PSDU (ACK/CTS).
//               Payload bits = 16 service + 14*8 data + 6 tail = 134 bits,
//               divided by data bits per symbol and rounded up.
// Ports       : ht_flag  in  1  rate_mcs is an HT MCS (else legacy rate code)
//               rate_mcs in  4  legacy rate code or HT MCS
//               n_sym    out 4  OFDM symbol count
// Revision    : 1.0 - initial release
// ============================================================================
module n_sym_len14_pkt
    import sifs_resp_sched_pkg::*;
(
    input  logic       ht_flag,
    input  logic [3:0] rate_mcs,
    output logic [3:0] n_sym
);

    always_comb begin
        n_sym = 4'd1;
        if (ht_flag) begin
            // 20 MHz, 1 stream, long GI: 26/52/78/104/156/... bits per symbol
            case (rate_mcs)
                4'd0:       n_sym = 4'd6;
                4'd1:       n_sym = 4'd3;
                4'd2, 4'd3: n_sym = 4'd2;
                default:    n_sym = 4'd1;
            endcase
        end else begin
            case (rate_mcs)
                c_RATE_6M:  n_sym = 4'd6;   // 24 bits/sym
                c_RATE_9M:  n_sym = 4'd4;   // 36
                c_RATE_12M: n_sym = 4'd3;   // 48
                c_RATE_18M: n_sym = 4'd2;   // 72
                c_RATE_24M: n_sym = 4'd2;   // 96
                default:    n_sym = 4'd1;   // 144 and above
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sifs_resp_sched.sv
`default_nettype none
// ============================================================================
// Module      : sifs_resp_sched
// Description : Control-response scheduler. After a correctly received frame
//               addressed to us, schedules an ACK (data/mgmt) or CTS (RTS)
//               one SIFS later and holds the request (RA/duration/rate) for
//               the tx path until resp_ack, timeout or abort by a new rx
//               packet header. Bypasses CSMA backoff.
// Ports       : clk, rstn (sync, active-low), tsf_pulse_1M (1 us tick)
//               rx side : pkt_header_valid_strobe, signal_rate, FC_type,
//                         FC_subtype, duration, addr1, addr2, fcs_in_strobe,
//                         fcs_valid
//               config  : self_mac_addr, sifs_time, resp_enable, nav_zero
//               tx side : resp_ack in; resp_req, resp_is_cts, resp_ra,
//                         resp_duration, resp_rate, resp_drop out
// Revision    : 1.0 - initial release
// ============================================================================
module sifs_resp_sched
    import sifs_resp_sched_pkg::*;
#(
    parameter int PREAMBLE_SIG_US = 20,
    parameter int OFDM_SYM_US     = 4,
    parameter int LEAD_US         = 0,
    parameter int REQ_TIMEOUT_US  = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tsf_pulse_1M,
    input  logic        pkt_header_valid_strobe,
    input  logic [7:0]  signal_rate,
    input  logic [1:0]  FC_type,
    input  logic [3:0]  FC_subtype,
    input  logic [15:0] duration,
    input  logic [47:0] addr1,
    input  logic [47:0] addr2,
    input  logic [47:0] self_mac_addr,
    input  logic        fcs_in_strobe,
    input  logic        fcs_valid,
    input  logic [6:0]  sifs_time,
    input  logic [1:0]  resp_enable,
    input  logic        nav_zero,
    input  logic        resp_ack,
    output logic        resp_req,
    output logic        resp_is_cts,
    output logic [47:0] resp_ra,
    output logic [15:0] resp_duration,
    output logic [3:0]  resp_rate,
    output logic        resp_drop
);

    localparam logic [15:0] c_LEAD    = 16'(LEAD_US);
    localparam logic [15:0] c_TIMEOUT = 16'(REQ_TIMEOUT_US);
    localparam logic [15:0] c_PREAMB  = 16'(PREAMBLE_SIG_US);
    localparam logic [15:0] c_SYM     = 16'(OFDM_SYM_US);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic        r_req, w_req_nxt;
    logic        r_drop, w_drop_nxt;
    logic        r_is_cts, w_is_cts_nxt;
    logic [47:0] r_ra, w_ra_nxt;
    logic [15:0] r_dur, w_dur_nxt;
    logic [3:0]  r_rate, w_rate_nxt;

    // ------------------------------------------------------------------
    // Response qualification and field computation (rx fields are stable
    // in the fcs_in_strobe cycle)
    // ------------------------------------------------------------------
    logic        w_addr_match;
    logic        w_ack_q;
    logic        w_cts_q;
    logic [3:0]  w_new_rate;
    logic [3:0]  w_n_sym;
    logic [15:0] w_resp_time;
    logic [15:0] w_overhead;
    logic [15:0] w_dur_field;
    logic [15:0] w_new_dur;
    logic [15:0] w_sifs_ext;
    logic [15:0] w_timer_init;
    logic        w_unused_rate_bits;

    assign w_unused_rate_bits = &{1'b0, signal_rate[6:4]};

    assign w_addr_match = (addr1 == self_mac_addr);
    assign w_ack_q = fcs_valid & resp_enable[0] & w_addr_match &
                     ((FC_type == c_FC_TYPE_MGMT) || (FC_type == c_FC_TYPE_DATA));
    assign w_cts_q = fcs_valid & resp_enable[1] & w_addr_match &
                     (FC_type == c_FC_TYPE_CTRL) & (FC_subtype == c_FC_SUBTYPE_RTS) &
                     nav_zero;

    assign w_new_rate = resp_rate_map(signal_rate[7], signal_rate[3:0]);

    // Symbol count of the response itself, i.e. at the rate about to be latched.
    n_sym_len14_pkt u_n_sym (
        .ht_flag  (1'b0),
        .rate_mcs (w_new_rate),
        .n_sym    (w_n_sym)
    );

    assign w_resp_time = c_PREAMB + c_SYM * {12'd0, w_n_sym};
    assign w_sifs_ext  = {9'd0, sifs_time};
    assign w_overhead  = w_sifs_ext + w_resp_time;
    assign w_dur_field = {1'b0, duration[14:0]};

    // Bit 15 set means the field carries an AID/CFP value, not a duration.
    // Otherwise subtract, saturating at zero.
    assign w_new_dur = duration[15]                ? 16'd0 :
                       (w_dur_field > w_overhead)  ? (w_dur_field - w_overhead) : 16'd0;

    assign w_timer_init = (w_sifs_ext > c_LEAD) ? (w_sifs_ext - c_LEAD) : 16'd0;

    // ------------------------------------------------------------------
    // FSM next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_req_nxt    = r_req;
        w_drop_nxt   = 1'b0;
        w_is_cts_nxt = r_is_cts;
        w_ra_nxt     = r_ra;
        w_dur_nxt    = r_dur;
        w_rate_nxt   = r_rate;

        case (r_state)
            ST_IDLE: begin
                // A header strobe in the same cycle outranks the FCS result.
                if (!pkt_header_valid_strobe && fcs_in_strobe && (w_ack_q || w_cts_q)) begin
                    w_is_cts_nxt = w_cts_q;
                    w_ra_nxt     = addr2;
                    w_dur_nxt    = w_new_dur;
                    w_rate_nxt   = w_new_rate;
                    w_timer_nxt  = w_timer_init;
                    w_state_nxt  = ST_SIFS_WAIT;
                end
            end

            ST_SIFS_WAIT: begin
                if (pkt_header_valid_strobe) begin
                    w_drop_nxt  = 1'b1;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == 16'd0) begin
                    w_req_nxt   = 1'b1;
                    w_timer_nxt = c_TIMEOUT;
                    w_state_nxt = ST_REQ;
                end else if (tsf_pulse_1M) begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end

            ST_REQ: begin
                if (pkt_header_valid_strobe) begin
                    w_req_nxt   = 1'b0;
                    w_drop_nxt  = 1'b1;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else if (resp_ack) begin
                    // Ack beats a coincident timeout.
                    w_req_nxt   = 1'b0;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else if ((r_timer == 16'd0) || (tsf_pulse_1M && (r_timer == 16'd1))) begin
                    w_req_nxt   = 1'b0;
                    w_drop_nxt  = 1'b1;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_IDLE;
                end else if (tsf_pulse_1M) begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end

            default: begin
                w_req_nxt   = 1'b0;
                w_timer_nxt = 16'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_timer  <= 16'd0;
            r_req    <= 1'b0;
            r_drop   <= 1'b0;
            r_is_cts <= 1'b0;
            r_ra     <= 48'd0;
            r_dur    <= 16'd0;
            r_rate   <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_req    <= w_req_nxt;
            r_drop   <= w_drop_nxt;
            r_is_cts <= w_is_cts_nxt;
            r_ra     <= w_ra_nxt;
            r_dur    <= w_dur_nxt;
            r_rate   <= w_rate_nxt;
        end
    end

    assign resp_req      = r_req;
    assign resp_drop     = r_drop;
    assign resp_is_cts   = r_is_cts;
    assign resp_ra       = r_ra;
    assign resp_duration = r_dur;
    assign resp_rate     = r_rate;

endmodule
`default_nettype wire
